// File: rtl/add_one_stim_chk.sv
// add_one_stim_chk: drives a programmable operand sequence into the add_one
// input channel and checks every returned result against operand+1.
module add_one_stim_chk #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_xfers,
  input  logic [DATA_W-1:0]  seed,
  input  logic [DATA_W-1:0]  step,
  input  logic               rx_stall,
  output logic               x_vld,
  output logic [DATA_W-1:0]  x_data,
  input  logic               x_busy,
  input  logic               return_vld,
  input  logic [DATA_W-1:0]  return_data,
  output logic               return_busy,
  output logic               done,
  output logic               pass,
  output logic [COUNT_W-1:0] sent_count,
  output logic [COUNT_W-1:0] rcv_count,
  output logic [COUNT_W-1:0] err_count,
  output logic [DATA_W-1:0]  first_err_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]  DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [AW:0]        PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [COUNT_W-1:0] num_r;
  logic [COUNT_W-1:0] sent_r;
  logic [COUNT_W-1:0] rcv_r;
  logic [COUNT_W-1:0] err_r;
  logic [DATA_W-1:0]  step_r;
  logic [DATA_W-1:0]  cur_r;
  logic [DATA_W-1:0]  first_err_r;
  logic               err_seen_r;
  logic [DATA_W-1:0]  fifo_mem_r [DEPTH];
  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;

  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic               active_s;
  logic               start_ok_s;
  logic               x_vld_s;
  logic               return_busy_s;
  logic               x_fire_s;
  logic               r_fire_s;
  logic               mismatch_s;
  logic [DATA_W-1:0]  exp_data_s;
  logic [COUNT_W-1:0] sent_inc_s;
  logic [COUNT_W-1:0] rcv_inc_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty_s  = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                         (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign active_s      = (state_r == RUN) || (state_r == DRAIN);
  assign start_ok_s    = start && ((state_r == IDLE) || (state_r == DONE));
  assign x_vld_s       = (state_r == RUN) && (sent_r < num_r) && !fifo_full_s;
  assign return_busy_s = rst || !active_s || fifo_empty_s || rx_stall;
  assign x_fire_s      = x_vld_s && !x_busy && !rst;
  assign r_fire_s      = return_vld && !return_busy_s;
  assign exp_data_s    = fifo_mem_r[rd_ptr_r[AW-1:0]];
  assign mismatch_s    = (return_data != exp_data_s);
  assign sent_inc_s    = sent_r + CNT_ONE;
  assign rcv_inc_s     = rcv_r + CNT_ONE;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_ok_s) begin
          state_s = (num_xfers == '0) ? DONE : RUN;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if ((sent_r == num_r) || (x_fire_s && (sent_inc_s == num_r))) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if ((rcv_r == num_r) || (r_fire_s && (rcv_inc_s == num_r))) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Expected-result storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (x_fire_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= cur_r + DATA_ONE;
    end
  end

  // Run parameters, operand generator, pointers and result checking.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_r       <= '0;
      step_r      <= '0;
      cur_r       <= '0;
      sent_r      <= '0;
      rcv_r       <= '0;
      err_r       <= '0;
      first_err_r <= '0;
      err_seen_r  <= 1'b0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
    end else if (start_ok_s) begin
      num_r       <= num_xfers;
      step_r      <= step;
      cur_r       <= seed;
      sent_r      <= '0;
      rcv_r       <= '0;
      err_r       <= '0;
      first_err_r <= '0;
      err_seen_r  <= 1'b0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
    end else begin
      if (x_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
        cur_r    <= cur_r + step_r;
        sent_r   <= sent_inc_s;
      end
      if (r_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        rcv_r    <= rcv_inc_s;
        if (mismatch_s) begin
          err_r <= sat_inc(err_r);
          if (!err_seen_r) begin
            first_err_r <= return_data;
            err_seen_r  <= 1'b1;
          end
        end
      end
    end
  end

  assign x_vld          = x_vld_s;
  assign x_data         = cur_r;
  assign return_busy    = return_busy_s;
  assign done           = (state_r == DONE);
  assign pass           = (state_r == DONE) && (err_r == '0);
  assign sent_count     = sent_r;
  assign rcv_count      = rcv_r;
  assign err_count      = err_r;
  assign first_err_data = first_err_r;

endmodule

// File: tb/tb_add_one_stim_chk.sv
// Bench for add_one_stim_chk: the bench plays the add_one block (result = operand+1,
// optionally corrupted) and checks the checker's counts against a sequence model.
module tb_add_one_stim_chk;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int COUNT_W = 16;

  logic               clk = 1'b0;
  logic               rst, start, rx_stall, x_busy, return_vld;
  logic [COUNT_W-1:0] num_xfers;
  logic [DATA_W-1:0]  seed, step, return_data;
  logic               x_vld, return_busy, done, pass;
  logic [DATA_W-1:0]  x_data, first_err_data;
  logic [COUNT_W-1:0] sent_count, rcv_count, err_count;

  add_one_stim_chk #(.DATA_W(DATA_W), .DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_xfers(num_xfers), .seed(seed), .step(step),
    .rx_stall(rx_stall), .x_vld(x_vld), .x_data(x_data), .x_busy(x_busy),
    .return_vld(return_vld), .return_data(return_data), .return_busy(return_busy),
    .done(done), .pass(pass), .sent_count(sent_count), .rcv_count(rcv_count),
    .err_count(err_count), .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Fake add_one state and observation bookkeeping.
  logic [31:0] resp_q[$];
  logic [31:0] sent_ops[$];
  bit          pend_rst, pend_start, force_busy, stall, busy_rand, stall_rand, gap_rand;
  bit          rf_prev, hold_pend, xvld_seen;
  logic [31:0] hold_data, corrupt_mask, corrupt_xor;
  int          ret_idx, hold_viol;

  task automatic tick();
    bit xf, rf;
    @(negedge clk);
    rst = pend_rst;     pend_rst = 1'b0;
    start = pend_start; pend_start = 1'b0;
    if (rf_prev) return_vld = 1'b0;
    if (rst) begin
      resp_q.delete();
      return_vld = 1'b0;
    end
    x_busy   = force_busy | (busy_rand & ($urandom_range(0, 2) == 0));
    rx_stall = stall | (stall_rand & ($urandom_range(0, 3) == 0));
    if (!rst && !return_vld && resp_q.size() > 0 && !(gap_rand && $urandom_range(0, 2) == 0)) begin
      return_data = resp_q.pop_front();
      if (ret_idx < 32 && corrupt_mask[ret_idx]) return_data = return_data ^ corrupt_xor;
      ret_idx++;
      return_vld = 1'b1;
    end
    #1;
    if (hold_pend && (x_vld !== 1'b1 || x_data !== hold_data)) hold_viol++;
    if (x_vld === 1'b1) xvld_seen = 1'b1;
    xf = (x_vld === 1'b1) && !x_busy && !rst;
    rf = return_vld && (return_busy === 1'b0);
    hold_pend = (x_vld === 1'b1) && x_busy && !rst;
    hold_data = x_data;
    if (xf) begin
      sent_ops.push_back(x_data);
      resp_q.push_back(x_data + 32'd1);
    end
    rf_prev = rf;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n, input logic [31:0] s, input logic [31:0] st);
    sent_ops.delete();
    ret_idx = 0; xvld_seen = 1'b0; hold_viol = 0; hold_pend = 1'b0;
    num_xfers = COUNT_W'(n); seed = s; step = st; pend_start = 1'b1;
    tick();
  endtask

  task automatic run_until_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) break;
      tick();
    end
  endtask

  // Reference: operand i of a run is seed + i*step (mod 2^32).
  function automatic int ops_bad(input logic [31:0] s, input logic [31:0] st, input int n);
    int bad = (sent_ops.size() != n) ? 1 : 0;
    for (int i = 0; i < sent_ops.size() && i < n; i++) begin
      logic [31:0] e = s + st * 32'(i);
      if (sent_ops[i] !== e) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    pend_rst = 1'b1;
    tick();
    checks++; if (x_vld !== 1'b0) begin errors++; $display("FAIL reset_x_vld: got %b want 0", x_vld); end
    checks++; if (return_busy !== 1'b1) begin errors++; $display("FAIL reset_return_busy: got %b want 1", return_busy); end
    checks++; if (done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL reset_done_pass: got %b%b want 00", done, pass); end
    checks++; if (sent_count !== 16'd0 || rcv_count !== 16'd0 || err_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", sent_count, rcv_count, err_count); end
    checks++; if (first_err_data !== 32'd0 || x_data !== 32'd0) begin
      errors++; $display("FAIL reset_data: got first_err=%0h x_data=%0h want 0/0", first_err_data, x_data); end
    tick();
    checks++; if (return_busy !== 1'b1 || x_vld !== 1'b0) begin errors++; $display("FAIL idle_outputs: got busy=%b vld=%b want 1/0", return_busy, x_vld); end
  endtask

  task automatic test_basic();
    start_run(4, 32'd5, 32'd1);
    checks++; if (x_vld !== 1'b1 || x_data !== 32'd5) begin
      errors++; $display("FAIL basic_latency: got vld=%b data=%0d want 1/5", x_vld, x_data); end
    run_until_done(100);
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL basic_done_pass: got %b%b want 11", done, pass); end
    checks++; if (ops_bad(32'd5, 32'd1, 4) !== 0) begin errors++; $display("FAIL basic_ops: got %0d bad operands want 0", ops_bad(32'd5, 32'd1, 4)); end
    checks++; if (sent_count !== 16'd4 || rcv_count !== 16'd4 || err_count !== 16'd0) begin
      errors++; $display("FAIL basic_counts: got %0d/%0d/%0d want 4/4/0", sent_count, rcv_count, err_count); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] s = $urandom;
    logic [31:0] st = $urandom;
    stall = 1'b1;
    start_run(10, s, st);
    for (int i = 0; i < 20; i++) tick();
    checks++; if (sent_count !== 16'(DEPTH) || sent_ops.size() != DEPTH) begin
      errors++; $display("FAIL bp_issued: got %0d want %0d", sent_count, DEPTH); end
    checks++; if (x_vld !== 1'b0 || x_data !== s + st * 32'd4) begin
      errors++; $display("FAIL bp_hold: got vld=%b data=%0h want 0/%0h", x_vld, x_data, s + st * 32'd4); end
    checks++; if (rcv_count !== 16'd0) begin errors++; $display("FAIL bp_rcv: got %0d want 0", rcv_count); end
    stall = 1'b0;
    run_until_done(200);
    checks++; if (done !== 1'b1 || pass !== 1'b1 || rcv_count !== 16'd10) begin
      errors++; $display("FAIL bp_release: got done=%b pass=%b rcv=%0d want 1/1/10", done, pass, rcv_count); end
    checks++; if (ops_bad(s, st, 10) !== 0) begin errors++; $display("FAIL bp_ops: got %0d bad want 0", ops_bad(s, st, 10)); end
  endtask

  task automatic test_producer_stall();
    start_run(6, 32'd100, 32'd3);
    tick();
    tick();
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (x_vld !== 1'b1 || x_data !== 32'd106) begin
        errors++; $display("FAIL pstall_hold%0d: got vld=%b data=%0d want 1/106", i, x_vld, x_data); end
    end
    force_busy = 1'b0;
    run_until_done(200);
    checks++; if (ops_bad(32'd100, 32'd3, 6) !== 0 || sent_count !== 16'd6) begin
      errors++; $display("FAIL pstall_ops: got %0d bad, sent=%0d want 0/6", ops_bad(32'd100, 32'd3, 6), sent_count); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL pstall_pass: got %b want 1", pass); end
  endtask

  task automatic test_wrap_error();
    start_run(2, 32'hFFFF_FFFF, 32'd1);
    run_until_done(100);
    checks++; if (pass !== 1'b1 || ops_bad(32'hFFFF_FFFF, 32'd1, 2) !== 0) begin
      errors++; $display("FAIL wrap_clean: got pass=%b want 1", pass); end
    corrupt_mask = 32'h1; corrupt_xor = 32'h5;
    start_run(2, 32'hFFFF_FFFF, 32'd1);
    run_until_done(100);
    checks++; if (err_count !== 16'd1 || first_err_data !== 32'h5) begin
      errors++; $display("FAIL wrap_err: got err=%0d first=%0h want 1/5", err_count, first_err_data); end
    checks++; if (done !== 1'b1 || pass !== 1'b0 || rcv_count !== 16'd2) begin
      errors++; $display("FAIL wrap_pass: got done=%b pass=%b rcv=%0d want 1/0/2", done, pass, rcv_count); end
    corrupt_mask = 32'hA; corrupt_xor = 32'h100;
    start_run(4, 32'd10, 32'd2);
    run_until_done(100);
    checks++; if (err_count !== 16'd2 || first_err_data !== 32'h10D) begin
      errors++; $display("FAIL multi_err: got err=%0d first=%0h want 2/10d", err_count, first_err_data); end
    corrupt_mask = 32'h0;
  endtask

  task automatic test_edge_starts();
    start_run(0, 32'd7, 32'd1);
    checks++; if (done !== 1'b1 || pass !== 1'b1 || sent_count !== 16'd0) begin
      errors++; $display("FAIL zero_done: got done=%b pass=%b sent=%0d want 1/1/0", done, pass, sent_count); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (xvld_seen !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL zero_vld: got seen=%b done=%b want 0/1", xvld_seen, done); end
    start_run(8, 32'd20, 32'd4);
    tick(); tick(); tick();
    num_xfers = 16'd2; seed = 32'hDEAD; step = 32'd9; pend_start = 1'b1;
    run_until_done(200);
    checks++; if (sent_count !== 16'd8 || rcv_count !== 16'd8 || pass !== 1'b1) begin
      errors++; $display("FAIL run_start_ignored: got sent=%0d rcv=%0d pass=%b want 8/8/1", sent_count, rcv_count, pass); end
    checks++; if (ops_bad(32'd20, 32'd4, 8) !== 0) begin errors++; $display("FAIL run_start_ops: got %0d bad want 0", ops_bad(32'd20, 32'd4, 8)); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s = $urandom;
    start_run(8, 32'd1, 32'd1);
    for (int i = 0; i < 50 && sent_count !== 16'd3; i++) tick();
    checks++; if (sent_count !== 16'd3) begin errors++; $display("FAIL mid_reach3: got %0d want 3", sent_count); end
    pend_rst = 1'b1;
    tick();
    checks++; if (x_vld !== 1'b0 || return_busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out: got vld=%b busy=%b done=%b want 0/1/0", x_vld, return_busy, done); end
    checks++; if (sent_count !== 16'd0 || rcv_count !== 16'd0 || err_count !== 16'd0) begin
      errors++; $display("FAIL mid_rst_counts: got %0d/%0d/%0d want 0/0/0", sent_count, rcv_count, err_count); end
    start_run(5, s, 32'd7);
    run_until_done(200);
    checks++; if (pass !== 1'b1 || rcv_count !== 16'd5 || ops_bad(s, 32'd7, 5) !== 0) begin
      errors++; $display("FAIL mid_rerun: got pass=%b rcv=%0d want 1/5", pass, rcv_count); end
  endtask

  task automatic test_random();
    busy_rand = 1'b1; stall_rand = 1'b1; gap_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int          n = $urandom_range(1, 12);
      logic [31:0] s = $urandom;
      logic [31:0] st = $urandom;
      int          exp_err = 0;
      logic [31:0] exp_first = 32'd0;
      corrupt_mask = (r % 2 == 1) ? $urandom : 32'h0;
      corrupt_xor  = $urandom | 32'h1;
      for (int i = 0; i < n; i++) begin
        if (corrupt_mask[i]) begin
          if (exp_err == 0) exp_first = (s + st * 32'(i) + 32'd1) ^ corrupt_xor;
          exp_err++;
        end
      end
      start_run(n, s, st);
      run_until_done(2000);
      checks++; if (done !== 1'b1 || sent_count !== 16'(n) || rcv_count !== 16'(n)) begin
        errors++; $display("FAIL rand%0d_done: got done=%b sent=%0d rcv=%0d want 1/%0d/%0d", r, done, sent_count, rcv_count, n, n); end
      checks++; if (err_count !== 16'(exp_err) || first_err_data !== exp_first || pass !== (exp_err == 0)) begin
        errors++; $display("FAIL rand%0d_err: got err=%0d first=%0h pass=%b want %0d/%0h", r, err_count, first_err_data, pass, exp_err, exp_first); end
      checks++; if (ops_bad(s, st, n) !== 0 || hold_viol !== 0) begin
        errors++; $display("FAIL rand%0d_ops: got bad=%0d hold_viol=%0d want 0/0", r, ops_bad(s, st, n), hold_viol); end
    end
    busy_rand = 1'b0; stall_rand = 1'b0; gap_rand = 1'b0; corrupt_mask = 32'h0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; num_xfers = '0; seed = '0; step = '0;
    rx_stall = 1'b0; x_busy = 1'b0; return_vld = 1'b0; return_data = '0;
    pend_rst = 1'b0; pend_start = 1'b0; force_busy = 1'b0; stall = 1'b0;
    busy_rand = 1'b0; stall_rand = 1'b0; gap_rand = 1'b0; rf_prev = 1'b0;
    hold_pend = 1'b0; xvld_seen = 1'b0; hold_data = '0; corrupt_mask = '0;
    corrupt_xor = '0; ret_idx = 0; hold_viol = 0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_producer_stall();
    test_wrap_error();
    test_edge_starts();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
